// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: stall/flush generation, redirect PC,
// control registers, exception/EXRT commit and interrupt detection.
module pipeline_ctrl #(
  parameter int          NUM_IRQ = 8,
  parameter logic [29:0] VEC_RST = 30'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_busy,
  input  logic               ld_hazard,
  input  logic               mem_busy,
  input  logic               mem_en,
  input  logic [29:0]        mem_pc,
  input  logic [1:0]         mem_ctrl_op,
  input  logic [4:0]         mem_dst_addr,
  input  logic [2:0]         mem_exp_code,
  input  logic [31:0]        mem_out,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [4:0]         creg_rd_addr,
  output logic [31:0]        creg_rd_data,
  output logic               exe_mode,
  output logic               int_detect,
  output logic               if_stall,
  output logic               id_stall,
  output logic               ex_stall,
  output logic               mem_stall,
  output logic               if_flush,
  output logic               id_flush,
  output logic               ex_flush,
  output logic               mem_flush,
  output logic [29:0]        new_pc
);

  typedef enum logic [1:0] {
    EV_NONE,
    EV_EXP,
    EV_EXRT,
    EV_WRCR
  } ev_e;

  localparam logic [1:0] OP_WRCR  = 2'd1;
  localparam logic [1:0] OP_EXRT  = 2'd2;
  localparam logic [2:0] EXP_TRAP = 3'd5;

  logic               exe_mode_q, exe_mode_d;
  logic               int_en_q, int_en_d;
  logic               pre_exe_mode_q, pre_exe_mode_d;
  logic               pre_int_en_q, pre_int_en_d;
  logic [29:0]        vector_q, vector_d;
  logic [2:0]         exp_code_q, exp_code_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [29:0]        epc_q, epc_d;

  ev_e  ev;
  logic stall;
  logic take;

  assign stall = if_busy | mem_busy;

  always_comb begin
    ev = EV_NONE;
    if (mem_en) begin
      if (mem_exp_code != 3'd0)       ev = EV_EXP;
      else if (mem_ctrl_op == OP_EXRT) ev = EV_EXRT;
      else if (mem_ctrl_op == OP_WRCR) ev = EV_WRCR;
    end
  end

  assign take = (ev != EV_NONE) & ~stall & ~reset;

  assign if_stall  = ~reset & (stall | ld_hazard);
  assign id_stall  = ~reset & stall;
  assign ex_stall  = ~reset & stall;
  assign mem_stall = ~reset & stall;

  // ld_hazard bubble goes into ID only when the pipe is moving
  assign if_flush  = take;
  assign id_flush  = take | (ld_hazard & ~stall & ~reset);
  assign ex_flush  = take;
  assign mem_flush = take;

  always_comb begin
    new_pc = '0;
    unique case (ev)
      EV_EXP:  new_pc = vector_q;
      EV_EXRT: new_pc = epc_q;
      EV_WRCR: new_pc = mem_pc + 30'd1;
      default: new_pc = '0;
    endcase
    if (reset) new_pc = '0;
  end

  assign exe_mode   = exe_mode_q;
  assign int_detect = int_en_q & (|(irq & ~mask_q));

  always_comb begin
    exe_mode_d     = exe_mode_q;
    int_en_d       = int_en_q;
    pre_exe_mode_d = pre_exe_mode_q;
    pre_int_en_d   = pre_int_en_q;
    vector_d       = vector_q;
    exp_code_d     = exp_code_q;
    mask_d         = mask_q;
    epc_d          = epc_q;
    if (take) begin
      unique case (ev)
        EV_EXP: begin
          pre_exe_mode_d = exe_mode_q;
          pre_int_en_d   = int_en_q;
          exe_mode_d     = 1'b0;
          int_en_d       = 1'b0;
          exp_code_d     = mem_exp_code;
          epc_d          = (mem_exp_code == EXP_TRAP)
                         ? mem_pc + 30'd1 : mem_pc;
        end
        EV_EXRT: begin
          exe_mode_d = pre_exe_mode_q;
          int_en_d   = pre_int_en_q;
        end
        EV_WRCR: begin
          unique case (mem_dst_addr)
            5'd0: begin
              int_en_d   = mem_out[1];
              exe_mode_d = mem_out[0];
            end
            5'd1: begin
              pre_int_en_d   = mem_out[1];
              pre_exe_mode_d = mem_out[0];
            end
            5'd2:    vector_d   = mem_out[31:2];
            5'd3:    exp_code_d = mem_out[2:0];
            5'd4:    mask_d     = mem_out[NUM_IRQ-1:0];
            5'd6:    epc_d      = mem_out[31:2];
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exe_mode_q     <= 1'b0;
      int_en_q       <= 1'b0;
      pre_exe_mode_q <= 1'b0;
      pre_int_en_q   <= 1'b0;
      vector_q       <= VEC_RST;
      exp_code_q     <= 3'd0;
      mask_q         <= '1;
      epc_q          <= '0;
    end else begin
      exe_mode_q     <= exe_mode_d;
      int_en_q       <= int_en_d;
      pre_exe_mode_q <= pre_exe_mode_d;
      pre_int_en_q   <= pre_int_en_d;
      vector_q       <= vector_d;
      exp_code_q     <= exp_code_d;
      mask_q         <= mask_d;
      epc_q          <= epc_d;
    end
  end

  always_comb begin
    creg_rd_data = '0;
    unique case (creg_rd_addr)
      5'd0:    creg_rd_data = {30'b0, int_en_q, exe_mode_q};
      5'd1:    creg_rd_data = {30'b0, pre_int_en_q, pre_exe_mode_q};
      5'd2:    creg_rd_data = {vector_q, 2'b00};
      5'd3:    creg_rd_data = {29'b0, exp_code_q};
      5'd4:    creg_rd_data = 32'(mask_q);
      5'd5:    creg_rd_data = 32'(irq);
      5'd6:    creg_rd_data = {epc_q, 2'b00};
      default: creg_rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Table-driven bench for pipeline_ctrl with a scoreboard queue of
// expected per-cycle outputs, plus a mid-operation reset sequence.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_busy, ld_hazard, mem_busy, mem_en;
  logic [29:0] mem_pc;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_out;
  logic [7:0]  irq;
  logic [4:0]  creg_rd_addr;
  logic [31:0] creg_rd_data;
  logic        exe_mode, int_detect;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic [29:0] new_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.NUM_IRQ(8), .VEC_RST(30'h0)) dut (
    .clk(clk), .reset(reset),
    .if_busy(if_busy), .ld_hazard(ld_hazard),
    .mem_busy(mem_busy), .mem_en(mem_en),
    .mem_pc(mem_pc), .mem_ctrl_op(mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr), .mem_exp_code(mem_exp_code),
    .mem_out(mem_out), .irq(irq),
    .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
    .exe_mode(exe_mode), .int_detect(int_detect),
    .if_stall(if_stall), .id_stall(id_stall),
    .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush),
    .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc(new_pc)
  );

  typedef struct {
    logic        ib, lh, mb, me;
    logic [29:0] pc;
    logic [1:0]  op;
    logic [4:0]  dst;
    logic [2:0]  ec;
    logic [31:0] dout;
    logic [7:0]  irq;
    logic [4:0]  ra;
    logic [3:0]  e_st;
    logic [3:0]  e_fl;
    logic [29:0] e_pc;
    logic        pcx;
    logic [31:0] e_rd;
    logic        e_mode, e_int;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic add(input logic ib, lh, mb, me,
                     input logic [29:0] pc, input logic [1:0] op,
                     input logic [4:0] dst, input logic [2:0] ec,
                     input logic [31:0] dout, input logic [7:0] iq,
                     input logic [4:0] ra, input logic [3:0] st, fl,
                     input logic [29:0] npc, input logic pcx,
                     input logic [31:0] rd, input logic md, id);
    vec_t v;
    v.ib = ib; v.lh = lh; v.mb = mb; v.me = me;
    v.pc = pc; v.op = op; v.dst = dst; v.ec = ec;
    v.dout = dout; v.irq = iq; v.ra = ra;
    v.e_st = st; v.e_fl = fl; v.e_pc = npc; v.pcx = pcx;
    v.e_rd = rd; v.e_mode = md; v.e_int = id;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_busy      = v.ib;
    ld_hazard    = v.lh;
    mem_busy     = v.mb;
    mem_en       = v.me;
    mem_pc       = v.pc;
    mem_ctrl_op  = v.op;
    mem_dst_addr = v.dst;
    mem_exp_code = v.ec;
    mem_out      = v.dout;
    irq          = v.irq;
    creg_rd_addr = v.ra;
  endtask

  task automatic idle();
    vec_t v;
    v = '{default: '0};
    drive(v);
  endtask

  initial begin
    vec_t e;
    reset = 1'b1;
    idle();
    // ib lh mb me pc op dst ec dout irq ra | st fl npc pcx rd mode int
    add(0,0,0,0,0,0,0,0,0,0, 0, 4'h0,4'h0,0,0, 0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 4, 4'h0,4'h0,0,0, 'hFF,0,0);
    add(0,0,0,1,'h10,1,2,0,'h100,0, 2, 4'h0,4'hF,'h11,0, 0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 2, 4'h0,4'h0,0,0, 'h100,0,0);
    add(0,0,0,1,'h100,0,0,5,0,0, 0, 4'h0,4'hF,'h40,0, 0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 6, 4'h0,4'h0,0,0, 'h404,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 3, 4'h0,4'h0,0,0, 5,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 0, 4'h0,4'h0,0,0, 0,0,0);
    add(0,0,0,1,'h200,1,0,0,3,0, 0, 4'h0,4'hF,'h201,0, 0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 0, 4'h0,4'h0,0,0, 3,1,0);
    add(0,0,0,1,'h3FFFFFFF,1,1,0,2,0, 1, 4'h0,4'hF,0,0, 0,1,0);
    add(0,0,0,1,'h50,2,0,0,0,0, 1, 4'h0,4'hF,'h101,0, 2,1,0);
    add(0,0,0,0,0,0,0,0,0,0, 0, 4'h0,4'h0,0,0, 2,0,0);
    add(0,0,0,1,'h20,1,4,0,'hFE,1, 4, 4'h0,4'hF,'h21,0, 'hFF,0,0);
    add(0,0,0,0,0,0,0,0,0,1, 4, 4'h0,4'h0,0,0, 'hFE,0,1);
    add(0,0,0,0,0,0,0,0,0,2, 5, 4'h0,4'h0,0,0, 2,0,0);
    for (int k = 0; k < 3; k++)
      add(0,0,1,1,'h77,0,0,2,0,3, 3, 4'hF,4'h0,0,1, 5,0,1);
    add(0,0,0,1,'h77,0,0,2,0,3, 3, 4'h0,4'hF,'h40,0, 5,0,1);
    add(0,0,0,0,0,0,0,0,0,3, 3, 4'h0,4'h0,0,0, 2,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 6, 4'h0,4'h0,0,0, 'h1DC,0,0);
    add(0,1,0,0,0,0,0,0,0,0, 0, 4'h8,4'h4,0,0, 0,0,0);
    add(0,0,0,1,'h90,2,0,4,0,0, 1, 4'h0,4'hF,'h40,0, 2,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 1, 4'h0,4'h0,0,0, 0,0,0);
    add(1,0,0,1,'h5,1,7,0,'hFFFFFFFF,0, 3, 4'hF,4'h0,0,1, 4,0,0);
    add(0,1,0,1,'h5,1,7,0,'hFFFFFFFF,0, 3, 4'h8,4'hF,6,0, 4,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 7, 4'h0,4'h0,0,0, 0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 3, 4'h0,4'h0,0,0, 4,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 2, 4'h0,4'h0,0,0, 'h100,0,0);

    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      #2;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", i, 1, 0);
      end else begin
        e = sb.pop_front();
        chk("stall", i,
            {if_stall, id_stall, ex_stall, mem_stall}, e.e_st);
        chk("flush", i,
            {if_flush, id_flush, ex_flush, mem_flush}, e.e_fl);
        if (!e.pcx) chk("new_pc", i, new_pc, e.e_pc);
        chk("rd_data", i, creg_rd_data, e.e_rd);
        chk("exe_mode", i, exe_mode, e.e_mode);
        chk("int_detect", i, int_detect, e.e_int);
      end
    end
    chk("scoreboard_drain", 0, sb.size(), 0);

    // Reset in the middle of a pending exception overrides it at once
    @(negedge clk);
    idle();
    mem_en = 1'b1; mem_exp_code = 3'd6; mem_pc = 30'h33;
    mem_busy = 1'b1; creg_rd_addr = 5'd2;
    #1;
    chk("pre_rst_stall", 100, mem_stall, 1);
    reset = 1'b1;
    #1;
    chk("rst_flush", 100,
        {if_flush, id_flush, ex_flush, mem_flush}, 0);
    chk("rst_stall", 100,
        {if_stall, id_stall, ex_stall, mem_stall}, 0);
    chk("rst_new_pc", 100, new_pc, 0);
    chk("rst_vector", 100, creg_rd_data, 0);
    creg_rd_addr = 5'd4;
    #1;
    chk("rst_mask", 100, creg_rd_data, 'hFF);
    mem_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle();
    creg_rd_addr = 5'd3;
    #2;
    chk("post_rst_cause", 101, creg_rd_data, 0);
    chk("post_rst_mode", 101, exe_mode, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
